// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lc3_ctrl_pkg
// Purpose  : Shared types and encodings for the LC-3 control FSM: the state
//            enum, opcode constants, and the PCMUX / ADDR2MUX / ALUK encodings.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_ctrl_pkg;

  typedef enum logic [5:0] {
    S_HALTED,
    S_18, S_RD_IF, S_35, S_32,
    S_01, S_05, S_09,
    S_00, S_22,
    S_12,
    S_04, S_21,
    S_14,
    S_02, S_06, S_10, S_RD_LDI, S_26, S_RD_LD, S_27,
    S_03, S_07, S_11, S_RD_STI, S_29, S_23, S_WR_ST,
    S_15, S_RD_TRAP, S_30,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_RTI   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LDI   = 4'b1010;
  localparam logic [3:0] OP_STI   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;
  localparam logic [3:0] OP_TRAP  = 4'b1111;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_BUS   = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // States that drive an SRAM access and are timed by the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_RD_IF)  || (s == S_RD_LD)  || (s == S_RD_LDI) ||
           (s == S_RD_STI) || (s == S_RD_TRAP) || (s == S_WR_ST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_wait_ctr
// Purpose  : Wait-state counter for SRAM phases. Cleared on clear_i, counts
//            up while enable_i, flags the last cycle of a MEM_WAIT-cycle phase.
// Ports    : Clk, Reset (sync, active-high), clear_i, enable_i -> done_o
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/lc3_ctrl_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lc3_ctrl_fsm
// Purpose  : LC-3 control FSM. Decodes the full opcode set and drives the
//            datapath load strobes, bus gates, mux selects and SRAM strobes.
//            SRAM phases are timed by mem_wait_ctr (MEM_WAIT cycles each).
// Ports    : Clk, Reset, Run, Continue, Opcode, IR_5, IR_11, BEN in;
//            LD_* loads, Gate* bus drivers, *MUX selects, ALUK,
//            Mem_CE/UB/LB (tied 0), Mem_OE/Mem_WE (active-low), Busy out.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Busy
);

  state_t state_q, state_d;
  logic   first_q;   // high in the first cycle after a state change
  logic   w_in_mem;
  logic   w_done;

  assign w_in_mem = is_mem_state(state_q);

  // Clearing outside memory states (and on the exit cycle) guarantees the
  // count is zero on entry to every phase.
  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear_i  (!w_in_mem || w_done),
    .enable_i (w_in_mem),
    .done_o   (w_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED:  if (Run) state_d = S_18;
      S_18:      state_d = S_RD_IF;
      S_RD_IF:   if (w_done) state_d = S_35;
      S_35:      state_d = S_32;
      S_32: begin
        case (Opcode)
          OP_ADD:   state_d = S_01;
          OP_AND:   state_d = S_05;
          OP_NOT:   state_d = S_09;
          OP_BR:    state_d = S_00;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_04;
          OP_LEA:   state_d = S_14;
          OP_LD:    state_d = S_02;
          OP_LDR:   state_d = S_06;
          OP_LDI:   state_d = S_10;
          OP_ST:    state_d = S_03;
          OP_STR:   state_d = S_07;
          OP_STI:   state_d = S_11;
          OP_TRAP:  state_d = S_15;
          OP_PAUSE: state_d = PAUSE_EN ? S_PAUSE1 : S_18;
          OP_RTI:   state_d = S_18;
        endcase
      end
      S_00:      state_d = BEN ? S_22 : S_18;
      S_04:      state_d = S_21;
      S_02, S_06: state_d = S_RD_LD;
      S_10:      state_d = S_RD_LDI;
      S_RD_LDI:  if (w_done) state_d = S_26;
      S_26:      state_d = S_RD_LD;
      S_RD_LD:   if (w_done) state_d = S_27;
      S_03, S_07: state_d = S_23;
      S_11:      state_d = S_RD_STI;
      S_RD_STI:  if (w_done) state_d = S_29;
      S_29:      state_d = S_23;
      S_23:      state_d = S_WR_ST;
      S_WR_ST:   if (w_done) state_d = S_18;
      S_15:      state_d = S_RD_TRAP;
      S_RD_TRAP: if (w_done) state_d = S_30;
      S_PAUSE1:  if (Continue) state_d = S_PAUSE2;
      S_PAUSE2:  if (!Continue) state_d = S_18;
      S_01, S_05, S_09, S_22, S_12, S_21, S_14, S_27, S_30:
                 state_d = S_18;
      default:   state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
    end
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;
  assign Busy   = (state_q != S_HALTED);

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_PC1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; MARMUX = 1'b0; ALUK = ALUK_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_PC1; LD_PC = 1'b1; end
      S_RD_IF, S_RD_LD, S_RD_LDI, S_RD_STI: begin
        Mem_OE = 1'b0;
        LD_MDR = w_done;
      end
      S_RD_TRAP: begin
        Mem_OE = 1'b0;
        LD_MDR = w_done;
        // R7 <- PC rides along with the first cycle of the vector read.
        if (first_q) begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      end
      S_WR_ST:   Mem_WE = 1'b0;
      S_35:      begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_32:      LD_BEN = 1'b1;
      S_01:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR2MUX = IR_5; ALUK = ALUK_ADD; end
      S_05:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR2MUX = IR_5; ALUK = ALUK_AND; end
      S_09:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_NOT; end
      S_22:      begin ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_12:      begin ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_04:      begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_21: begin
        ADDR1MUX = !IR_11;
        ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
      S_14:      begin ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1; LD_REG = 1'b1; end
      S_02, S_10, S_03, S_11: begin
        ADDR2MUX = ADDR2_OFF9; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_06, S_07: begin
        ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_26, S_29: begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      S_27:      begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_23:      begin SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_15:      begin MARMUX = 1'b1; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      S_30:      begin GateMDR = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1; end
      S_PAUSE1:  LD_LED = first_q;
      default:   ;
    endcase
  end

endmodule
`default_nettype wire
